// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared constants, types and operand classification for the FPU divider
package fp_div_pkg;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS = 127;
   localparam int EXP_MAX = 255;
   localparam logic [MAN_W-1:0] QNAN_MAN = 23'h400000;
   localparam logic [1:0] RM_RNE = 2'b00;
   localparam logic [1:0] RM_RZ = 2'b01;
   localparam logic [1:0] RM_RUP = 2'b10;
   localparam logic [1:0] RM_RDN = 2'b11;
   typedef enum logic [1:0] {IDLE, DIV, RND, DONE} state_t;
   typedef enum logic [2:0] {SC_NONE, SC_NAN, SC_INF, SC_DIVZ, SC_ZERO} sc_t;
   typedef struct packed {
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] m;
   } fp_res_t;
   typedef struct packed {
      logic invalid;
      logic overflow;
      logic underflow;
      logic inexact;
      logic zero;
      logic divzero;
   } fp_flags_t;
   function automatic sc_t fp_classify(input logic [EXP_W-1:0] ex, input logic [MAN_W-1:0] mx,
                                       input logic [EXP_W-1:0] ey, input logic [MAN_W-1:0] my);
      logic xz, yz, xi, yi, xn, yn;
      xz = ex == '0;
      yz = ey == '0;
      xi = ex == EXP_W'(EXP_MAX) && mx == '0;
      yi = ey == EXP_W'(EXP_MAX) && my == '0;
      xn = ex == EXP_W'(EXP_MAX) && mx != '0;
      yn = ey == EXP_W'(EXP_MAX) && my != '0;
      return (xn | yn | (xz & yz) | (xi & yi)) ? SC_NAN :
             xi ? SC_INF : yz ? SC_DIVZ : (xz | yi) ? SC_ZERO : SC_NONE;
   endfunction
endpackage

// File: rtl/fp_div_if.sv
// fp_div_if: operand/result/flag bundle between the FPU top and the divider
interface fp_div_if;
   import fp_div_pkg::*;
   logic start;
   logic Sx, Sy;
   logic [EXP_W-1:0] Ex, Ey;
   logic [MAN_W-1:0] Mx, My;
   logic [1:0] R_mode;
   logic busy, done, Sz;
   logic [EXP_W-1:0] Ez;
   logic [MAN_W-1:0] Mz;
   logic invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag, divzero_flag;
   modport master (
      output start, Sx, Sy, Ex, Ey, Mx, My, R_mode,
      input busy, done, Sz, Ez, Mz,
      input invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag, divzero_flag
   );
   modport slave (
      input start, Sx, Sy, Ex, Ey, Mx, My, R_mode,
      output busy, done, Sz, Ez, Mz,
      output invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag, divzero_flag
   );
endinterface

// File: rtl/fp_div_round.sv
// fp_div_round: rounds a normalised 24-bit significand with guard/round/sticky and packs exponent/fraction with flags
module fp_div_round
   import fp_div_pkg::*;
(
   input  logic              sign,
   input  logic signed [9:0] e,
   input  logic [23:0]       q,
   input  logic              g,
   input  logic              r,
   input  logic              s,
   input  logic [1:0]        rm,
   output fp_res_t           res,
   output logic              ovf,
   output logic              unf,
   output logic              inx,
   output logic              zro
);
   logic grs, inc, away;
   logic [24:0] mant;
   logic signed [9:0] e_r;
   always_comb begin
      grs = g | r | s;
      inc = rm == RM_RNE ? g & (r | s | q[0]) :
            rm == RM_RUP ? ~sign & grs :
            rm == RM_RDN ? sign & grs : 1'b0;
      away = rm == RM_RNE || (rm == RM_RUP && !sign) || (rm == RM_RDN && sign);
      mant = {1'b0, q} + {24'd0, inc};
      e_r = e + $signed({9'd0, mant[24]});
      ovf = e_r >= 10'sd255;
      unf = e_r <= 10'sd0;
      inx = ovf | unf | grs;
      zro = unf;
      // a carry out leaves the hidden bit clear, which is exactly when the fraction must be zero
      res.e = ovf ? (away ? EXP_W'(EXP_MAX) : EXP_W'(EXP_MAX - 1)) : unf ? '0 : e_r[EXP_W-1:0];
      res.m = ((ovf & away) | unf) ? '0 : ovf ? '1 : mant[23] ? mant[22:0] : '0;
   end
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative binary32 divider, one quotient bit per cycle; FP_DIV_EARLY_TERM_EN exits on zero remainder
module fp_div_seq
   import fp_div_pkg::*;
(
   input logic     CLK,
   input logic     RST,
   fp_div_if.slave bus
);
   state_t state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic [24:0] r_q, r_d, r_sub;
   logic [23:0] b_q, b_d, a;
   logic [25:0] q_q, q_d, q_sh;
   logic signed [9:0] e_q, e_d;
   logic sign_q, sign_d, busy_q, busy_d, done_q, done_d, sz_q, sz_d, ge, adj;
   logic [1:0] rm_q, rm_d;
   fp_res_t res_q, res_d, rnd_res;
   fp_flags_t fl_q, fl_d;
   logic r_ovf, r_unf, r_inx, r_zro;
   sc_t sc;

   fp_div_round u_round (
      .sign(sign_q), .e(e_q), .q(q_q[25:2]), .g(q_q[1]), .r(q_q[0]), .s(|r_q), .rm(rm_q),
      .res(rnd_res), .ovf(r_ovf), .unf(r_unf), .inx(r_inx), .zro(r_zro)
   );

   always_comb begin
      ge = r_q >= {1'b0, b_q};
      r_sub = ge ? r_q - {1'b0, b_q} : r_q;
      q_sh = {q_q[24:0], ge};
      a = {1'b1, bus.Mx};
      adj = a < {1'b1, bus.My};
      sc = fp_classify(bus.Ex, bus.Mx, bus.Ey, bus.My);
      state_d = state_q;
      cnt_d = cnt_q;
      r_d = r_q;
      b_d = b_q;
      q_d = q_q;
      e_d = e_q;
      sign_d = sign_q;
      rm_d = rm_q;
      busy_d = busy_q;
      done_d = 1'b0;
      sz_d = sz_q;
      res_d = res_q;
      fl_d = fl_q;
      case (state_q)
         IDLE: if (bus.start) begin
            sign_d = bus.Sx ^ bus.Sy;
            rm_d = bus.R_mode;
            state_d = sc == SC_NONE ? DIV : DONE;
            busy_d = sc == SC_NONE;
            done_d = sc != SC_NONE;
            b_d = {1'b1, bus.My};
            // pre-shifting when A<B keeps the quotient in [1,2)
            r_d = adj ? {a, 1'b0} : {1'b0, a};
            e_d = {2'b00, bus.Ex} - {2'b00, bus.Ey} + 10'(BIAS) - {9'd0, adj};
            cnt_d = 5'd25;
            q_d = '0;
            if (sc != SC_NONE) begin
               sz_d = sc != SC_NAN && (bus.Sx ^ bus.Sy);
               res_d.e = sc == SC_ZERO ? '0 : EXP_W'(EXP_MAX);
               res_d.m = sc == SC_NAN ? QNAN_MAN : '0;
               fl_d = '0;
               fl_d.invalid = sc == SC_NAN;
               fl_d.divzero = sc == SC_DIVZ;
               fl_d.zero = sc == SC_ZERO;
            end
         end
         DIV: begin
            r_d = r_sub << 1;
            q_d = q_sh;
            cnt_d = cnt_q - 5'd1;
            state_d = cnt_q == 5'd0 ? RND : DIV;
`ifdef FP_DIV_EARLY_TERM_EN
            if (r_sub == '0) begin
               q_d = q_sh << cnt_q;
               state_d = RND;
            end
`endif
         end
         RND: begin
            state_d = DONE;
            busy_d = 1'b0;
            done_d = 1'b1;
            sz_d = sign_q;
            res_d = rnd_res;
            fl_d = '0;
            fl_d.overflow = r_ovf;
            fl_d.underflow = r_unf;
            fl_d.inexact = r_inx;
            fl_d.zero = r_zro;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q <= '0;
         r_q <= '0;
         b_q <= '0;
         q_q <= '0;
         e_q <= '0;
         sign_q <= 1'b0;
         rm_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sz_q <= 1'b0;
         res_q <= '0;
         fl_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         r_q <= r_d;
         b_q <= b_d;
         q_q <= q_d;
         e_q <= e_d;
         sign_q <= sign_d;
         rm_q <= rm_d;
         busy_q <= busy_d;
         done_q <= done_d;
         sz_q <= sz_d;
         res_q <= res_d;
         fl_q <= fl_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.Sz = sz_q;
   assign bus.Ez = res_q.e;
   assign bus.Mz = res_q.m;
   assign bus.invalid_flag = fl_q.invalid;
   assign bus.overflow_flag = fl_q.overflow;
   assign bus.underflow_flag = fl_q.underflow;
   assign bus.inexact_flag = fl_q.inexact;
   assign bus.zero_flag = fl_q.zero;
   assign bus.divzero_flag = fl_q.divzero;
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed scoreboard bench for fp_div_seq
module tb_fp_div_seq;
   import fp_div_pkg::*;
   localparam logic [5:0] F_INV = 6'b100000, F_OVF = 6'b010000, F_UNF = 6'b001000;
   localparam logic [5:0] F_INX = 6'b000100, F_ZRO = 6'b000010, F_DZ = 6'b000001;
   typedef struct {
      logic sz;
      logic [7:0] ez;
      logic [22:0] mz;
      logic [5:0] fl;
      int lat;
   } exp_t;
   logic CLK = 1'b0;
   logic RST = 1'b0;
   exp_t sb[$];
   int checks = 0;
   int errs = 0;
   fp_div_if bus();
   fp_div_seq dut (.CLK(CLK), .RST(RST), .bus(bus));
   always #5 CLK = ~CLK;

   function automatic logic [5:0] flags();
      return {bus.invalid_flag, bus.overflow_flag, bus.underflow_flag,
              bus.inexact_flag, bus.zero_flag, bus.divzero_flag};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                        input logic sy, input logic [7:0] ey, input logic [22:0] my, input logic [1:0] rm);
      @(negedge CLK);
      bus.Sx = sx; bus.Ex = ex; bus.Mx = mx;
      bus.Sy = sy; bus.Ey = ey; bus.My = my;
      bus.R_mode = rm;
      bus.start = 1'b1;
      @(posedge CLK);
      #1 bus.start = 1'b0;
   endtask

   task automatic op(input string tag, input logic sx, input logic [7:0] ex, input logic [22:0] mx,
                     input logic sy, input logic [7:0] ey, input logic [22:0] my, input logic [1:0] rm,
                     input logic esz, input logic [7:0] eez, input logic [22:0] emz, input logic [5:0] efl,
                     input int elat, input bit poke);
      exp_t x, e;
      int n;
      x.sz = esz; x.ez = eez; x.mz = emz; x.fl = efl; x.lat = elat;
      sb.push_back(x);
      drive(sx, ex, mx, sy, ey, my, rm);
      n = 1;
      @(negedge CLK);
      if (elat > 1) chk({tag, "/busy"}, 32'(bus.busy), 1);
      while (!bus.done && n < 40) begin
         bus.start = poke && n == 10;
         if (poke && n == 10) bus.Ex = 8'd200;
         @(posedge CLK);
         n++;
         @(negedge CLK);
      end
      bus.start = 1'b0;
      e = sb.pop_front();
      chk({tag, "/done"}, 32'(bus.done), 1);
`ifdef FP_DIV_EARLY_TERM_EN
      chk({tag, "/lat_le"}, 32'(n <= e.lat), 1);
`else
      chk({tag, "/lat"}, n, e.lat);
`endif
      chk({tag, "/Sz"}, 32'(bus.Sz), 32'(e.sz));
      chk({tag, "/Ez"}, 32'(bus.Ez), 32'(e.ez));
      chk({tag, "/Mz"}, 32'(bus.Mz), 32'(e.mz));
      chk({tag, "/flags"}, 32'(flags()), 32'(e.fl));
      bus.start = poke;
      @(posedge CLK);
      #1 bus.start = 1'b0;
      @(negedge CLK);
      chk({tag, "/pulse"}, 32'(bus.done), 0);
      if (poke) chk({tag, "/start_in_done"}, 32'(bus.busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      bus.start = 1'b0;
      bus.Sx = 1'b0; bus.Ex = '0; bus.Mx = '0;
      bus.Sy = 1'b0; bus.Ey = '0; bus.My = '0;
      bus.R_mode = RM_RNE;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;
      @(negedge CLK);
      chk("reset/busy", 32'(bus.busy), 0);
      chk("reset/done", 32'(bus.done), 0);
      chk("reset/result", {bus.Sz, bus.Ez, bus.Mz}, 0);
      chk("reset/flags", 32'(flags()), 0);
      op("6/2", 0, 129, 23'h400000, 0, 128, 0, RM_RNE, 0, 128, 23'h400000, 0, 28, 0);
      op("1/3 rne", 0, 127, 0, 0, 128, 23'h400000, RM_RNE, 0, 125, 23'h2AAAAB, F_INX, 28, 1);
      op("1/3 rz", 0, 127, 0, 0, 128, 23'h400000, RM_RZ, 0, 125, 23'h2AAAAA, F_INX, 28, 0);
      op("1/3 rup", 0, 127, 0, 0, 128, 23'h400000, RM_RUP, 0, 125, 23'h2AAAAB, F_INX, 28, 0);
      op("1/3 rdn", 0, 127, 0, 0, 128, 23'h400000, RM_RDN, 0, 125, 23'h2AAAAA, F_INX, 28, 0);
      op("-1/3 rdn", 1, 127, 0, 0, 128, 23'h400000, RM_RDN, 1, 125, 23'h2AAAAB, F_INX, 28, 0);
      op("-1/3 rup", 1, 127, 0, 0, 128, 23'h400000, RM_RUP, 1, 125, 23'h2AAAAA, F_INX, 28, 0);
      op("-5/0", 1, 129, 23'h200000, 0, 0, 0, RM_RNE, 1, 255, 0, F_DZ, 1, 0);
      op("0/0", 0, 0, 0, 0, 0, 0, RM_RNE, 0, 255, 23'h400000, F_INV, 1, 0);
      op("inf/inf", 0, 255, 0, 1, 255, 0, RM_RNE, 0, 255, 23'h400000, F_INV, 1, 0);
      op("nan/1", 1, 255, 1, 0, 127, 0, RM_RZ, 0, 255, 23'h400000, F_INV, 1, 1);
      op("inf/-2", 0, 255, 0, 1, 128, 0, RM_RNE, 1, 255, 0, 0, 1, 0);
      op("3/inf", 0, 128, 23'h400000, 0, 255, 0, RM_RNE, 0, 0, 0, F_ZRO, 1, 0);
      op("-0/5", 1, 0, 0, 0, 129, 23'h200000, RM_RNE, 1, 0, 0, F_ZRO, 1, 0);
      op("subn/1", 0, 0, 5, 0, 127, 0, RM_RNE, 0, 0, 0, F_ZRO, 1, 0);
      op("max/0.5 rne", 0, 254, 23'h7FFFFF, 0, 126, 0, RM_RNE, 0, 255, 0, F_OVF | F_INX, 28, 0);
      op("max/0.5 rz", 0, 254, 23'h7FFFFF, 0, 126, 0, RM_RZ, 0, 254, 23'h7FFFFF, F_OVF | F_INX, 28, 0);
      op("max/0.5 rdn", 0, 254, 23'h7FFFFF, 0, 126, 0, RM_RDN, 0, 254, 23'h7FFFFF, F_OVF | F_INX, 28, 0);
      op("max/0.5 rup", 0, 254, 23'h7FFFFF, 0, 126, 0, RM_RUP, 0, 255, 0, F_OVF | F_INX, 28, 0);
      op("-max/0.5 rdn", 1, 254, 23'h7FFFFF, 0, 126, 0, RM_RDN, 1, 255, 0, F_OVF | F_INX, 28, 0);
      op("-max/0.5 rup", 1, 254, 23'h7FFFFF, 0, 126, 0, RM_RUP, 1, 254, 23'h7FFFFF, F_OVF | F_INX, 28, 0);
      op("tiny/huge", 0, 1, 0, 0, 254, 0, RM_RNE, 0, 0, 0, F_UNF | F_INX | F_ZRO, 28, 0);
      op("1.5/1.5", 0, 127, 23'h400000, 0, 127, 23'h400000, RM_RNE, 0, 127, 0, 0, 28, 0);
      drive(0, 129, 23'h400000, 0, 128, 0, RM_RNE);
      repeat (9) @(posedge CLK);
      #1 RST = 1'b0;
      @(posedge CLK);
      #1 RST = 1'b1;
      @(negedge CLK);
      chk("abort/busy", 32'(bus.busy), 0);
      chk("abort/done", 32'(bus.done), 0);
      chk("abort/result", {bus.Sz, bus.Ez, bus.Mz}, 0);
      chk("abort/flags", 32'(flags()), 0);
      seen = 0;
      repeat (35) begin
         @(negedge CLK);
         seen += int'(bus.done);
      end
      chk("abort/no_done", seen, 0);
      op("6/2 after abort", 0, 129, 23'h400000, 1, 128, 0, RM_RNE, 1, 128, 23'h400000, 0, 28, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
